// File: rtl/axi3_master_if.sv
// AXI3 bus bundle between a single-beat master and its slave.
//
// Parameters: ADDR (address width), DATA (data width), ID (AXI ID width).
// Channels:   AW, W, B (write) and AR, R (read), standard AXI3 widths,
//             plus AxQOS carried for interconnects that expect it.
// Modports:   master - drives AW/W/AR payload+valid and bready/rready
//             slave  - drives awready/wready/arready and the B/R channels
interface axi3_master_if #(
  parameter int ADDR = 32,
  parameter int DATA = 32,
  parameter int ID   = 12
);
  // write address channel
  logic [ID-1:0]     awid;
  logic [ADDR-1:0]   awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic [3:0]        awqos;
  logic              awvalid;
  logic              awready;
  // write data channel
  logic [ID-1:0]     wid;
  logic [DATA-1:0]   wdata;
  logic [DATA/8-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  // write response channel
  logic [ID-1:0]     bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  // read address channel
  logic [ID-1:0]     arid;
  logic [ADDR-1:0]   araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;
  // read data channel
  logic [ID-1:0]     rid;
  logic [DATA-1:0]   rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi3_master.sv
// Single-beat AXI3 master: turns a simple request/acknowledge port into one
// AXI3 write (AW+W, then B) or read (AR, then R) transaction at a time.
//
// Parameters: ADDR, DATA (power of two, 8..1024), ID, MYID (ID driven on
//             awid/wid/arid), TIMEOUT (cycles before abandon), TIMEBITS
//             (timer width).
// Ports:      clk, reset (async, active-high)
//             inreq/inwr in, inack out        - request pulse, write select, done pulse
//             inaddr/inwdata/inwstrb in       - request address, write data, strobes
//             inrdata/inerr out               - read data and error, valid with inack
//             axi (axi3_master_if.master)     - AXI3 bus
// Option:     define AXI3_MASTER_TIMEOUT_EN to abandon a transaction after
//             TIMEOUT non-idle cycles (inack with inerr=1, inrdata=0).
module axi3_master #(
  parameter int ADDR     = 32,
  parameter int DATA     = 32,
  parameter int ID       = 12,
  parameter int MYID     = 0,
  parameter int TIMEOUT  = 1048575,
  parameter int TIMEBITS = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inreq,
  input  logic              inwr,
  output logic              inack,
  input  logic [ADDR-1:0]   inaddr,
  input  logic [DATA-1:0]   inwdata,
  input  logic [DATA/8-1:0] inwstrb,
  output logic [DATA-1:0]   inrdata,
  output logic              inerr,
  axi3_master_if.master     axi
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WADDR = 3'd1;
  localparam logic [2:0] WRESP = 3'd2;
  localparam logic [2:0] RADDR = 3'd3;
  localparam logic [2:0] RDATA = 3'd4;

  localparam logic [2:0]    SIZE = 3'($clog2(DATA / 8));
  localparam logic [ID-1:0] AXID = ID'(MYID);

  logic [2:0]        state_q, state_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              inack_q, inack_d;
  logic              inerr_q, inerr_d;
  logic              rerr_q, rerr_d;
  logic [DATA-1:0]   inrdata_q, inrdata_d;

  logic [ADDR-1:0]   addr_q;
  logic [DATA-1:0]   wdata_q;
  logic [DATA/8-1:0] wstrb_q;

  logic              req_take;
  logic              tmo;

  assign req_take = (state_q == IDLE) && inreq;

`ifdef AXI3_MASTER_TIMEOUT_EN
  logic [TIMEBITS-1:0] timer_q;

  // Loaded with TIMEOUT-1 on accept so the abandon edge lands exactly
  // TIMEOUT cycles after leaving IDLE.
  assign tmo = (state_q != IDLE) && (timer_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (req_take) begin
      timer_q <= TIMEBITS'(TIMEOUT - 1);
    end else if ((state_q != IDLE) && (timer_q != '0)) begin
      timer_q <= timer_q - 1'b1;
    end
  end
`else
  localparam int unused_cfg = TIMEOUT + TIMEBITS;
  assign tmo = 1'b0;
`endif

  // Request capture: payload held here keeps AW/W/AR stable while valid.
  always_ff @(posedge clk) begin
    if (req_take) begin
      addr_q  <= inaddr;
      wdata_q <= inwdata;
      wstrb_q <= inwstrb;
    end
  end

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    inack_d   = 1'b0;
    inerr_d   = inerr_q;
    rerr_d    = rerr_q;
    inrdata_d = inrdata_q;

    case (state_q)
      IDLE: begin
        if (inreq) begin
          rerr_d = 1'b0;
          if (inwr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WADDR: begin
        // AW and W complete independently; a channel already done counts as
        // ready so either ordering (or both together) reaches WRESP.
        if (awvalid_q && axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
        if ((!awvalid_q || axi.awready) && (!wvalid_q || axi.wready)) begin
          state_d = WRESP;
        end
      end
      WRESP: begin
        if (axi.bvalid) begin
          state_d = IDLE;
          inack_d = 1'b1;
          inerr_d = axi.bresp[1];
        end
      end
      RADDR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (axi.rvalid) begin
          // Error is sticky over every beat; only the last beat's data is kept.
          rerr_d = rerr_q | axi.rresp[1];
          if (axi.rlast) begin
            state_d   = IDLE;
            inack_d   = 1'b1;
            inerr_d   = rerr_q | axi.rresp[1];
            inrdata_d = axi.rdata;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (tmo) begin
      state_d   = IDLE;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      inack_d   = 1'b1;
      inerr_d   = 1'b1;
      inrdata_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      inack_q   <= 1'b0;
      inerr_q   <= 1'b0;
      rerr_q    <= 1'b0;
      inrdata_q <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      inack_q   <= inack_d;
      inerr_q   <= inerr_d;
      rerr_q    <= rerr_d;
      inrdata_q <= inrdata_d;
    end
  end

  assign inack   = inack_q;
  assign inerr   = inerr_q;
  assign inrdata = inrdata_q;

  // Write address: single INCR beat, full bus width, no lock/cache/prot/qos.
  assign axi.awid    = AXID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = SIZE;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awqos   = 4'd0;
  assign axi.awvalid = awvalid_q;

  assign axi.wid     = AXID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;

  // Responses are accepted while idle too, so stray beats drain silently.
  assign axi.bready  = (state_q == IDLE) || (state_q == WRESP);

  assign axi.arid    = AXID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = SIZE;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arqos   = 4'd0;
  assign axi.arvalid = arvalid_q;

  assign axi.rready  = (state_q == IDLE) || (state_q == RDATA);

  // IDs and the low response bit carry no meaning for a single-ID master.
  logic unused_sig;
  assign unused_sig = ^{axi.bid, axi.rid, axi.bresp[0], axi.rresp[0]};

endmodule

// File: tb/tb_axi3_master.sv
module tb_axi3_master;
  localparam int ADDR     = 32;
  localparam int DATA     = 32;
  localparam int ID       = 12;
  localparam int MYID     = 12'h05A;
  localparam int TIMEOUT  = 16;
  localparam int TIMEBITS = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              inreq, inwr, inack, inerr;
  logic [ADDR-1:0]   inaddr;
  logic [DATA-1:0]   inwdata, inrdata;
  logic [DATA/8-1:0] inwstrb;

  axi3_master_if #(.ADDR(ADDR), .DATA(DATA), .ID(ID)) axi ();

  axi3_master #(
    .ADDR(ADDR), .DATA(DATA), .ID(ID), .MYID(MYID),
    .TIMEOUT(TIMEOUT), .TIMEBITS(TIMEBITS)
  ) dut (
    .clk(clk), .reset(reset),
    .inreq(inreq), .inwr(inwr), .inack(inack),
    .inaddr(inaddr), .inwdata(inwdata), .inwstrb(inwstrb),
    .inrdata(inrdata), .inerr(inerr),
    .axi(axi)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexp(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL unexpected_%s: handshake with nothing expected at %0t", name, $time);
  endtask

  typedef struct {
    logic [DATA-1:0] rdata;
    logic            err;
    logic            chk_rd;
  } resp_t;

  logic [ADDR-1:0]        q_aw[$];
  logic [ADDR-1:0]        q_ar[$];
  logic [DATA+DATA/8-1:0] q_w[$];
  resp_t                  q_resp[$];

  // Slave behaviour knobs
  int              aw_dly, w_dly, ar_dly;
  int              aw_cnt, w_cnt, ar_cnt;
  logic [1:0]      b_resp;
  int              b_owed, r_owed, r_n, r_idx;
  logic [DATA-1:0] r_data[4];
  logic [1:0]      r_resp[4];

  // Slave drivers: act on negedge, DUT samples on the following posedge.
  initial forever begin
    @(negedge clk);
    if (axi.awvalid) begin axi.awready = (aw_cnt >= aw_dly); aw_cnt++; end
    else begin axi.awready = 1'b0; aw_cnt = 0; end
  end
  initial forever begin
    @(negedge clk);
    if (axi.wvalid) begin axi.wready = (w_cnt >= w_dly); w_cnt++; end
    else begin axi.wready = 1'b0; w_cnt = 0; end
  end
  initial forever begin
    @(negedge clk);
    if (axi.arvalid) begin axi.arready = (ar_cnt >= ar_dly); ar_cnt++; end
    else begin axi.arready = 1'b0; ar_cnt = 0; end
  end
  initial forever begin
    @(negedge clk);
    axi.bvalid = 1'b0;
    if (b_owed > 0 && axi.bready) begin
      axi.bvalid = 1'b1;
      axi.bresp  = b_resp;
      axi.bid    = 12'hFFF;
      b_owed--;
    end
  end
  initial forever begin
    @(negedge clk);
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    if (r_owed > 0 && axi.rready) begin
      axi.rvalid = 1'b1;
      axi.rdata  = r_data[r_idx];
      axi.rresp  = r_resp[r_idx];
      axi.rid    = 12'hABC;
      axi.rlast  = (r_idx == r_n - 1);
      if (r_idx == r_n - 1) begin r_idx = 0; r_owed--; end
      else r_idx++;
    end
  end

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    #2;
    if (axi.awvalid && axi.awready) begin
      if (q_aw.size() == 0) unexp("aw");
      else begin
        chk("awaddr", axi.awaddr, q_aw.pop_front());
        chk("awlen", axi.awlen, 0);
        chk("awsize", axi.awsize, 2);
        chk("awburst", axi.awburst, 1);
        chk("awid", axi.awid, MYID);
      end
    end
    if (axi.wvalid && axi.wready) begin
      if (q_w.size() == 0) unexp("w");
      else begin
        chk("wdata_wstrb", {axi.wdata, axi.wstrb}, q_w.pop_front());
        chk("wlast", axi.wlast, 1);
        chk("wid", axi.wid, MYID);
      end
      b_owed++;
    end
    if (axi.arvalid && axi.arready) begin
      if (q_ar.size() == 0) unexp("ar");
      else begin
        chk("araddr", axi.araddr, q_ar.pop_front());
        chk("arlen", axi.arlen, 0);
        chk("arsize", axi.arsize, 2);
        chk("arid", axi.arid, MYID);
      end
      r_owed++;
    end
    if (inack) begin
      if (q_resp.size() == 0) unexp("inack");
      else begin
        resp_t e;
        e = q_resp.pop_front();
        chk("inerr", inerr, e.err);
        if (e.chk_rd) chk("inrdata", inrdata, e.rdata);
      end
    end
  end

  // Issues one request at a negedge and returns at the negedge where inack
  // is seen high (cyc = negedges elapsed since the request was driven).
  task automatic do_req(input logic wr, input logic [ADDR-1:0] addr,
                        input logic [DATA-1:0] wd, input logic [DATA/8-1:0] ws,
                        input logic [DATA-1:0] erd, input logic eerr, input logic chk_rd,
                        input bit addr_hs, input bit spur, output int cyc);
    resp_t e;
    if (wr) begin
      q_aw.push_back(addr);
      q_w.push_back({wd, ws});
    end else if (addr_hs) begin
      q_ar.push_back(addr);
    end
    e.rdata = erd; e.err = eerr; e.chk_rd = chk_rd;
    q_resp.push_back(e);
    inwr = wr; inaddr = addr; inwdata = wd; inwstrb = ws; inreq = 1'b1;
    @(negedge clk);
    cyc = 1;
    // scramble the request inputs: the DUT must use its latched copy
    inaddr = 32'hBAD0_BAD0; inwdata = 32'h5555_AAAA; inwstrb = 4'h0;
    if (!spur) inreq = 1'b0;
    chk("valid_after_req", wr ? axi.awvalid : axi.arvalid, 1);
    if (spur) begin @(negedge clk); cyc++; inreq = 1'b0; end
    while (inack !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (inack !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL inack_timeout: no inack after %0d cycles, addr 0x%0h", cyc, addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    inreq = 0; inwr = 0; inaddr = '0; inwdata = '0; inwstrb = '0;
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
    axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0; axi.rid = 0;
    aw_dly = 0; w_dly = 0; ar_dly = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    b_resp = 0; b_owed = 0; r_owed = 0; r_n = 1; r_idx = 0;
    for (int i = 0; i < 4; i++) begin r_data[i] = '0; r_resp[i] = '0; end
    reset = 1'b1;

    repeat (3) @(negedge clk);
    #2;
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_inack", inack, 0);
    chk("rst_inerr", inerr, 0);
    chk("rst_inrdata", inrdata, 0);
    chk("rst_bready", axi.bready, 1);
    chk("rst_rready", axi.rready, 1);

    // Write, AW and W accepted together, OKAY; request on first edge after reset
    @(negedge clk);
    reset = 1'b0;
    do_req(1, 32'h100, 32'hDEADBEEF, 4'hF, '0, 0, 0, 1, 0, cyc);
    chk("w1_latency", cyc, 3);

    // Same write, wready 3 cycles after awready; extra inreq while busy ignored
    aw_dly = 0; w_dly = 3;
    do_req(1, 32'h100, 32'hDEADBEEF, 4'hF, '0, 0, 0, 1, 1, cyc);
    chk("w2_latency", cyc, 6);

    // Read with SLVERR
    w_dly = 0;
    r_n = 1; r_data[0] = 32'h12345678; r_resp[0] = 2'b10;
    do_req(0, 32'h200, '0, '0, 32'h12345678, 1, 1, 1, 0, cyc);
    chk("r1_latency", cyc, 3);

    // Back-to-back read issued while inack is high; error in a non-last beat
    r_n = 3;
    r_data[0] = 32'h11111111; r_resp[0] = 2'b10;
    r_data[1] = 32'h22222222; r_resp[1] = 2'b00;
    r_data[2] = 32'h33333333; r_resp[2] = 2'b00;
    do_req(0, 32'h204, '0, '0, 32'h33333333, 1, 1, 1, 0, cyc);

    // Two-beat clean read: error accumulator restarts per request
    r_n = 2;
    r_data[0] = 32'h0BADF00D; r_resp[0] = 2'b00;
    r_data[1] = 32'hA5A5C3C3; r_resp[1] = 2'b01;
    do_req(0, 32'h208, '0, '0, 32'hA5A5C3C3, 0, 1, 1, 0, cyc);

    // W before AW, SLVERR
    aw_dly = 2; w_dly = 0; b_resp = 2'b10;
    do_req(1, 32'h10C, 32'h01020304, 4'b0101, '0, 1, 0, 1, 0, cyc);

    // EXOKAY is not an error; inrdata keeps the last read value
    aw_dly = 0; b_resp = 2'b01;
    do_req(1, 32'h110, 32'hFFFF0000, 4'b0011, 32'hA5A5C3C3, 0, 1, 1, 0, cyc);

    // Stray B and R in IDLE: drained, no inack, outputs untouched
    b_resp = 2'b10;
    r_n = 1; r_data[0] = 32'hEEEEEEEE; r_resp[0] = 2'b10;
    @(negedge clk);
    #3;
    b_owed = 1; r_owed = 1;
    repeat (4) @(negedge clk);
    #2;
    chk("stray_b_drained", b_owed, 0);
    chk("stray_r_drained", r_owed, 0);
    chk("stray_inrdata", inrdata, 32'hA5A5C3C3);
    chk("stray_inerr", inerr, 0);

    // Reset in the middle of WADDR
    b_resp = 2'b00;
    aw_dly = 1000; w_dly = 1000;
    @(negedge clk);
    inwr = 1; inaddr = 32'h300; inreq = 1;
    @(negedge clk);
    inreq = 0;
    @(negedge clk);
    chk("pre_rst_awvalid", axi.awvalid, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_awvalid", axi.awvalid, 0);
    chk("midrst_wvalid", axi.wvalid, 0);
    chk("midrst_inrdata", inrdata, 0);
    @(negedge clk);
    aw_dly = 0; w_dly = 0;
    reset = 1'b0;
    do_req(1, 32'h300, 32'hCAFEF00D, 4'hF, '0, 0, 0, 1, 0, cyc);
    chk("post_rst_latency", cyc, 3);

`ifdef AXI3_MASTER_TIMEOUT_EN
    // arready never comes: inack 16 cycles after entering RADDR (17 negedges
    // after the request was driven), arvalid dropped, error with zero data
    ar_dly = 1000;
    do_req(0, 32'h400, '0, '0, '0, 1, 1, 0, 0, cyc);
    chk("tmo_latency", cyc, 17);
    chk("tmo_arvalid", axi.arvalid, 0);
    ar_dly = 0;
    r_n = 1; r_data[0] = 32'h600DF00D; r_resp[0] = 2'b00;
    do_req(0, 32'h404, '0, '0, 32'h600DF00D, 0, 1, 1, 0, cyc);
`endif

    repeat (4) @(negedge clk);
    chk("q_resp_empty", q_resp.size(), 0);
    chk("q_aw_empty", q_aw.size(), 0);
    chk("q_w_empty", q_w.size(), 0);
    chk("q_ar_empty", q_ar.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
